// File: rtl/vdp_timing_pkg.sv
// Shared types and widths for the raster timing generator and its counter.
package vdp_timing_pkg;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } raster_state_e;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic line_end;
    logic frame_end;
    logic hold;
  } raster_flags_t;

  // Flags of a frozen raster: nothing visible, no sync, no pulses.
  localparam raster_flags_t FLAGS_IDLE = '{
    active: 1'b0, hsync: 1'b0, vsync: 1'b0,
    line_end: 1'b0, frame_end: 1'b0, hold: 1'b1
  };

endpackage

// File: rtl/vdp_raster_counter.sv
// Raster position counters with a frame-boundary hold.
// state | meaning
// HOLD  | raster frozen at (0,0), waiting for hold_request to drop
// RUN   | x/y advance every pixel; hold is only honoured on the last pixel of a frame
import vdp_timing_pkg::*;

module vdp_raster_counter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hold_request,
  output logic [H_CNT_W-1:0] raster_x,
  output logic [V_CNT_W-1:0] raster_y,
  output raster_state_e      state
);

  localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(V_TOTAL - 1);

  raster_state_e      state_q, state_d;
  logic [H_CNT_W-1:0] x_q, x_d;
  logic [V_CNT_W-1:0] y_q, y_d;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      HOLD: begin
        x_d = '0;
        y_d = '0;
        if (!hold_request) state_d = RUN;
      end
      RUN: begin
        if (x_q == H_LAST) begin
          x_d = '0;
          if (y_q == V_LAST) begin
            y_d = '0;
            if (hold_request) state_d = HOLD;
          end else begin
            y_d = y_q + V_CNT_W'(1);
          end
        end else begin
          x_d = x_q + H_CNT_W'(1);
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= HOLD;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign raster_x = x_q;
  assign raster_y = y_q;
  assign state    = state_q;

endmodule

// File: rtl/vdp_raster_timing.sv
// Video raster timing: position counters (S0), sync/pulse decode and a
// two-stage pipeline aligning colour, syncs and pulses at S2.
import vdp_timing_pkg::*;

module vdp_raster_timing #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hold_request,
  output logic [H_CNT_W-1:0] raster_x,
  output logic [V_CNT_W-1:0] raster_y,
  output logic               raster_active,
  input  logic [3:0]         pixel_r,
  input  logic [3:0]         pixel_g,
  input  logic [3:0]         pixel_b,
  output logic [3:0]         r,
  output logic [3:0]         g,
  output logic [3:0]         b,
  output logic               hsync,
  output logic               vsync,
  output logic               line_ended,
  output logic               frame_ended,
  output logic               holding_raster
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_CNT_W-1:0] H_ACT_END  = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] H_SYNC_BEG = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] H_SYNC_END = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_ACT_END  = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_SYNC_BEG = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] V_SYNC_END = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);

  raster_state_e state;
  logic          run;
  raster_flags_t flags_s0;
  raster_flags_t s1_q, s1_d;

  logic [3:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       line_ended_q, line_ended_d, frame_ended_q, frame_ended_d;
  logic       holding_q, holding_d;

  vdp_raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_counter (
    .clk          (clk),
    .reset_n      (reset_n),
    .hold_request (hold_request),
    .raster_x     (raster_x),
    .raster_y     (raster_y),
    .state        (state)
  );

  assign run           = (state == RUN);
  assign raster_active = run && (raster_x < H_ACT_END) && (raster_y < V_ACT_END);

  // Every S0 flag is gated by RUN so a frozen raster carries only the hold flag.
  always_comb begin
    flags_s0 = FLAGS_IDLE;
    if (run) begin
      flags_s0.hold      = 1'b0;
      flags_s0.active    = raster_active;
      flags_s0.hsync     = (raster_x >= H_SYNC_BEG) && (raster_x < H_SYNC_END);
      flags_s0.vsync     = (raster_y >= V_SYNC_BEG) && (raster_y < V_SYNC_END);
      flags_s0.line_end  = (raster_x == H_LAST);
      flags_s0.frame_end = (raster_x == H_LAST) && (raster_y == V_LAST);
    end
  end

  always_comb begin
    s1_d          = flags_s0;
    r_d           = s1_q.active ? pixel_r : 4'd0;
    g_d           = s1_q.active ? pixel_g : 4'd0;
    b_d           = s1_q.active ? pixel_b : 4'd0;
    hsync_d       = s1_q.hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d       = s1_q.vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    line_ended_d  = s1_q.line_end;
    frame_ended_d = s1_q.frame_end;
    holding_d     = s1_q.hold;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q          <= FLAGS_IDLE;
      r_q           <= 4'd0;
      g_q           <= 4'd0;
      b_q           <= 4'd0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      line_ended_q  <= 1'b0;
      frame_ended_q <= 1'b0;
      holding_q     <= 1'b1;
    end else begin
      s1_q          <= s1_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_ended_q  <= line_ended_d;
      frame_ended_q <= frame_ended_d;
      holding_q     <= holding_d;
    end
  end

  assign r              = r_q;
  assign g              = g_q;
  assign b              = b_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign line_ended     = line_ended_q;
  assign frame_ended    = frame_ended_q;
  assign holding_raster = holding_q;

endmodule
